// File: rtl/pipemdu_pkg.sv
// pipemdu_pkg: shared constants for the EX-stage multiply/divide unit.
//   - MDU op encodings carried on eop
//   - FSM state type
//   - iteration count of the shift/add and restoring-divide loops
package pipemdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int unsigned MDU_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/pipemdu_if.sv
// pipemdu_if: E-stage request / HI-LO response bundle between the pipeline and the MDU.
//   master (pipeline): estart, eop, emthi, emtlo, ea, eb, duse -> ; <- hi, lo, busy, mdstall
//   slave  (MDU)     : the reverse directions
interface pipemdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             estart;
    logic [1:0]       eop;
    logic             emthi;
    logic             emtlo;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic             duse;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             mdstall;

    modport master (
        output estart, eop, emthi, emtlo, ea, eb, duse,
        input  hi, lo, busy, mdstall
    );

    modport slave (
        input  estart, eop, emthi, emtlo, ea, eb, duse,
        output hi, lo, busy, mdstall
    );
endinterface

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement negate, used for operand magnitudes and result fixup.
//   value  in  W  operand
//   enable in  1  negate when high, pass through otherwise
//   result out W  enable ? -value : value (modulo 2^W)
module mdu_negate #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         enable,
    output logic [W-1:0] result
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    assign result = enable ? (~value + ONE) : value;

endmodule

// File: rtl/pipemdu.sv
// pipemdu: iterative 32-cycle multiply/divide unit with HI/LO for the EX stage.
//   clock, reset : posedge clock, synchronous active-high reset
//   bus (slave)  : estart/eop start an op, emthi/emtlo write ea to HI/LO while idle,
//                  duse flags a D-stage HI/LO user; hi/lo/busy out, mdstall = busy & duse
// Ops run on magnitudes and the sign is applied in a single FIX cycle after 32 iterations.
module pipemdu
    import pipemdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    pipemdu_if.slave  bus
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(MDU_ITERS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MDU_ITERS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;     // {acc, multiplier} or {rem, quot}
    logic [WIDTH-1:0] opb_q, opb_d;     // multiplicand or divisor magnitude
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             isdiv_q, isdiv_d;
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Start decode
    logic op_signed, op_div;
    assign op_signed = (bus.eop == MDU_MULT) || (bus.eop == MDU_DIV);
    assign op_div    = (bus.eop == MDU_DIV)  || (bus.eop == MDU_DIVU);

    logic [WIDTH-1:0] a_mag, b_mag;

    mdu_negate #(.W(WIDTH)) u_neg_a (
        .value  (bus.ea),
        .enable (op_signed & bus.ea[WIDTH-1]),
        .result (a_mag)
    );

    mdu_negate #(.W(WIDTH)) u_neg_b (
        .value  (bus.eb),
        .enable (op_signed & bus.eb[WIDTH-1]),
        .result (b_mag)
    );

    // Result fixup
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    mdu_negate #(.W(W2)) u_neg_prod (
        .value  (acc_q),
        .enable (negq_q),
        .result (prod_fix)
    );

    // Divide by zero keeps the all-ones quotient unsigned-looking.
    mdu_negate #(.W(WIDTH)) u_neg_quot (
        .value  (acc_q[WIDTH-1:0]),
        .enable (negq_q & ~divz_q),
        .result (quot_fix)
    );

    // For x/0 the remainder is |ea|; negating it when ea < 0 restores ea exactly.
    mdu_negate #(.W(WIDTH)) u_neg_rem (
        .value  (acc_q[W2-1:WIDTH]),
        .enable (negr_q),
        .result (rem_fix)
    );

    // Iteration step datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] rem_sh, rem_sub;
    logic             rem_carry, rem_ge;

    assign mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opb_q};
    // Shifted remainder is WIDTH+1 bits: carry out of the top plus rem_sh.
    assign rem_carry = acc_q[W2-1];
    assign rem_sh    = {acc_q[W2-2:WIDTH], acc_q[WIDTH-1]};
    assign rem_ge    = rem_carry | (rem_sh >= opb_q);
    assign rem_sub   = rem_sh - opb_q;  // true difference is < 2^WIDTH whenever rem_ge

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        isdiv_d = isdiv_q;
        divz_d  = divz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.estart) begin
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    opb_d   = b_mag;
                    negq_d  = op_signed & (bus.ea[WIDTH-1] ^ bus.eb[WIDTH-1]);
                    negr_d  = op_signed & op_div & bus.ea[WIDTH-1];
                    isdiv_d = op_div;
                    divz_d  = op_div & (bus.eb == '0);
                    cnt_d   = '0;
                    state_d = ITER;
                end else begin
                    if (bus.emthi) hi_d = bus.ea;
                    if (bus.emtlo) lo_d = bus.ea;
                end
            end

            ITER: begin
                if (isdiv_q) begin
                    acc_d = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                                   : {rem_sh,  acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                     : {1'b0, acc_q[W2-1:WIDTH], acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) state_d = FIX;
            end

            FIX: begin
                if (isdiv_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[W2-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            isdiv_q <= 1'b0;
            divz_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            isdiv_q <= isdiv_d;
            divz_q  <= divz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.mdstall = (state_q != IDLE) & bus.duse;

endmodule

// File: tb/tb_pipemdu.sv
// tb_pipemdu: self-checking bench for pipemdu; reference results come from plain
// 64-bit integer arithmetic on the architectural mult/div definitions.
module tb_pipemdu;

    logic clock;
    logic reset;
    int   tests_run = 0;
    int   failed    = 0;

    pipemdu_if #(.WIDTH(32)) bus ();

    pipemdu #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", failed);
        $fatal(1, "watchdog");
    end

    // Reference model
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sp, sq, sr;
        logic [63:0] ua, ub, up;
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                h = sp[63:32];
                l = sp[31:0];
            end
            2'b01: begin
                up = ua * ub;
                h = up[63:32];
                l = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFFFFFF;
                end else if (op == 2'b10) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    h = sr[31:0];
                    l = sq[31:0];
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
        endcase
    endfunction

    // Starts an op at the current negedge and waits for busy to drop; returns at the
    // first negedge with busy low so a following op can start immediately.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic du, output logic [31:0] h, output logic [31:0] l,
                          output int cycles, output int stalls);
        bus.estart = 1'b1;
        bus.eop    = op;
        bus.ea     = a;
        bus.eb     = b;
        bus.duse   = du;
        @(negedge clock);
        bus.estart = 1'b0;
        bus.ea     = $urandom;
        bus.eb     = $urandom;
        cycles = 0;
        stalls = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (bus.mdstall === 1'b1) stalls++;
            @(negedge clock);
        end
        h = bus.hi;
        l = bus.lo;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.duse = 1'b1;
        repeat (3) @(negedge clock);
        tests_run++;
        if (bus.busy !== 1'b0) begin
            failed++; $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        tests_run++;
        if (bus.mdstall !== 1'b0) begin
            failed++; $display("FAIL reset_mdstall got %b want 0", bus.mdstall);
        end
        tests_run++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failed++; $display("FAIL reset_hilo got %h/%h want 0/0", bus.hi, bus.lo);
        end
        reset    = 1'b0;
        bus.duse = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [1:0]  ops [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10};
        logic [31:0] as  [7] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd7,
                                 32'h12345678, 32'h12345678, 32'h80000000};
        logic [31:0] bs  [7] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic [31:0] ehs [7] = '{32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd1,
                                 32'h12345678, 32'h12345678, 32'd0};
        logic [31:0] els [7] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'd3,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] h, l;
        int c, s;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, h, l, c, s);
            tests_run++;
            if (h !== ehs[i] || l !== els[i]) begin
                failed++;
                $display("FAIL directed[%0d] hi/lo got %h/%h want %h/%h", i, h, l, ehs[i], els[i]);
            end
            tests_run++;
            if (c != 33) begin
                failed++; $display("FAIL directed[%0d]_busy_cycles got %0d want 33", i, c);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, h, l, eh, el;
        int c, s;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(op, a, b, eh, el);
            run_op(op, a, b, 1'b0, h, l, c, s);
            tests_run++;
            if (h !== eh || l !== el || c != 33 || s != 0) begin
                failed++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got hi=%h lo=%h cyc=%0d stall=%0d want hi=%h lo=%h cyc=33 stall=0",
                         i, op, a, b, h, l, c, s, eh, el);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] h, l, eh, el;
        int c, s;
        model(2'b00, 32'h00012345, 32'hFFFF0001, eh, el);
        run_op(2'b00, 32'h00012345, 32'hFFFF0001, 1'b1, h, l, c, s);
        tests_run++;
        if (s != 33) begin
            failed++; $display("FAIL stall_cycles got %0d want 33", s);
        end
        tests_run++;
        if (bus.mdstall !== 1'b0) begin
            failed++; $display("FAIL stall_after_fix got %b want 0", bus.mdstall);
        end
        tests_run++;
        if (h !== eh || l !== el) begin
            failed++; $display("FAIL stall_result got %h/%h want %h/%h", h, l, eh, el);
        end
        bus.duse = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo_before;
        lo_before = bus.lo;
        bus.emthi = 1'b1;
        bus.ea    = 32'd5;
        @(negedge clock);
        bus.emthi = 1'b0;
        tests_run++;
        if (bus.hi !== 32'd5 || bus.lo !== lo_before) begin
            failed++;
            $display("FAIL mthi got hi=%h lo=%h want hi=00000005 lo=%h", bus.hi, bus.lo, lo_before);
        end
        bus.emtlo = 1'b1;
        bus.ea    = 32'hCAFE0001;
        @(negedge clock);
        bus.emtlo = 1'b0;
        tests_run++;
        if (bus.lo !== 32'hCAFE0001 || bus.hi !== 32'd5) begin
            failed++;
            $display("FAIL mtlo got hi=%h lo=%h want hi=00000005 lo=cafe0001", bus.hi, bus.lo);
        end
    endtask

    task automatic test_ignore_when_busy();
        logic [31:0] h0, l0, eh, el;
        int c;
        h0 = bus.hi;
        l0 = bus.lo;
        model(2'b01, 32'h9ABCDEF0, 32'h13579BDF, eh, el);
        bus.estart = 1'b1;
        bus.eop    = 2'b01;
        bus.ea     = 32'h9ABCDEF0;
        bus.eb     = 32'h13579BDF;
        @(negedge clock);
        bus.estart = 1'b0;
        c = 0;
        while (bus.busy === 1'b1 && c < 100) begin
            c++;
            if (c == 3 || c == 20) begin
                bus.estart = 1'b1;
                bus.emthi  = 1'b1;
                bus.emtlo  = 1'b1;
                bus.eop    = 2'b10;
                bus.ea     = 32'hDEADBEEF;
                bus.eb     = 32'd0;
            end else begin
                bus.estart = 1'b0;
                bus.emthi  = 1'b0;
                bus.emtlo  = 1'b0;
            end
            if (c == 10) begin
                tests_run++;
                if (bus.hi !== h0 || bus.lo !== l0) begin
                    failed++;
                    $display("FAIL busy_hilo_hold got %h/%h want %h/%h", bus.hi, bus.lo, h0, l0);
                end
            end
            @(negedge clock);
        end
        bus.estart = 1'b0;
        bus.emthi  = 1'b0;
        bus.emtlo  = 1'b0;
        tests_run++;
        if (bus.hi !== eh || bus.lo !== el || c != 33) begin
            failed++;
            $display("FAIL busy_ignore got hi=%h lo=%h cyc=%0d want hi=%h lo=%h cyc=33",
                     bus.hi, bus.lo, c, eh, el);
        end
    endtask

    task automatic test_midreset();
        logic [31:0] h, l;
        int c, s;
        bus.emthi = 1'b1;
        bus.emtlo = 1'b1;
        bus.ea    = 32'h55AA55AA;
        @(negedge clock);
        bus.emthi  = 1'b0;
        bus.emtlo  = 1'b0;
        bus.estart = 1'b1;
        bus.eop    = 2'b00;
        bus.ea     = 32'h00001234;
        bus.eb     = 32'h00005678;
        @(negedge clock);
        bus.estart = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failed++;
            $display("FAIL midreset got busy=%b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        run_op(2'b11, 32'd100, 32'd7, 1'b0, h, l, c, s);
        tests_run++;
        if (h !== 32'd2 || l !== 32'd14 || c != 33) begin
            failed++;
            $display("FAIL midreset_divu got hi=%h lo=%h cyc=%0d want 2/14/33", h, l, c);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l, eh, el;
        int c, s;
        run_op(2'b10, 32'hFFFFF000, 32'd7, 1'b0, h, l, c, s);
        model(2'b10, 32'hFFFFF000, 32'd7, eh, el);
        tests_run++;
        if (h !== eh || l !== el) begin
            failed++; $display("FAIL b2b_first got %h/%h want %h/%h", h, l, eh, el);
        end
        run_op(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, h, l, c, s);
        model(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, eh, el);
        tests_run++;
        if (h !== eh || l !== el || c != 33) begin
            failed++;
            $display("FAIL b2b_second got %h/%h cyc=%0d want %h/%h cyc=33", h, l, c, eh, el);
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.estart = 1'b0;
        bus.eop    = 2'b00;
        bus.emthi  = 1'b0;
        bus.emtlo  = 1'b0;
        bus.ea     = 32'd0;
        bus.eb     = 32'd0;
        bus.duse   = 1'b0;
        @(negedge clock);
        test_reset();
        test_directed();
        test_stall();
        test_mthi_mtlo();
        test_ignore_when_busy();
        test_midreset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/pipemdu.md
# pipemdu

EX-stage iterative multiply/divide unit with HI/LO registers for the 5-stage pipelined CPU. It consumes the E-stage operands and control from the ID/EX pipeline register, computes the result over 32 iteration cycles, and drives the stall back toward the D stage. The stall holds D-stage instructions that need HI/LO while an operation is in flight. Non-MDU instructions keep flowing; an MDU instruction advances to M immediately after it starts.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `estart`  in  1  E-stage instruction is mult/multu/div/divu and valid.
- `eop`  in  2  op code: 00 mult, 01 multu, 10 div, 11 divu.
- `emthi`  in  1  E-stage mthi; write `ea` to HI.
- `emtlo`  in  1  E-stage mtlo; write `ea` to LO.
- `ea`  in  32  rs operand; multiplicand or dividend.
- `eb`  in  32  rt operand; multiplier or divisor.
- `duse`  in  1  D-stage instruction is mfhi/mflo/mthi/mtlo/mult/div.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  operation in flight.
- `mdstall`  out  1  `busy & duse`; combinational; freezes PC and IF/ID, bubbles ID/EX.

## Operation
- States: IDLE, ITER, FIX.
- **IDLE**
  - If `estart` is high: latch |ea| and |eb|. Magnitudes apply to signed ops only; unsigned ops take raw values.
  - Latch `neg_q` = signed op and sign(ea) ≠ sign(eb).
  - Latch `neg_r` = signed div and ea[31].
  - Latch op class. Clear accumulator and count. Go to ITER.
  - Else if `emthi`/`emtlo` is high: write `ea` to HI/LO; stay in IDLE.
  - `estart` has priority over `emthi`/`emtlo`. Decode never asserts them together.
- **ITER** (32 cycles, count 0..31)
  - Mult: radix-2 shift-add on a 64-bit {acc, multiplier} register, LSB first.
  - Div: restoring division on a 64-bit {rem, quot} register, one quotient bit per cycle, MSB first.
  - At count = 31, go to FIX.
- **FIX** (1 cycle)
  - Mult: the 64-bit product is negated if `neg_q`. HI = product[63:32], LO = product[31:0].
  - Div: LO = quotient, negated if `neg_q`. HI = remainder, negated if `neg_r`.
  - Return to IDLE.
- Divide by zero (eb = 0, either div op): HI = ea, LO = 32'hFFFFFFFF. No sign fixup; the cycle count is unchanged.
- Signed div of 32'h80000000 by 32'hFFFFFFFF gives LO = 32'h80000000, HI = 0. This falls out of the magnitude path; no special case.
- `estart`, `emthi` and `emtlo` are ignored outside IDLE. `mdstall` guarantees they never arrive there; the bench checks HI/LO are not corrupted if they do.
- HI/LO change only on an mthi/mtlo write in IDLE and on the FIX edge.
- All width arithmetic is modulo 2^32 (2^64 for the product register). There is no overflow exception.

## Timing
- Reset (synchronous, any state, including mid-ITER):
  - state = IDLE, HI = LO = 0, busy = 0.
  - Iteration registers cleared; any in-flight operation is aborted.
- A start sampled at edge E0 makes `busy` = 1 after E0.
  - ITER occupies edges E1..E32; FIX is at edge E33.
  - HI/LO are valid and `busy` = 0 after E33. `busy` is high for exactly 33 cycles.
- mthi/mtlo: HI/LO updated at the sampling edge, visible the next cycle.
- `mdstall` is combinational from `busy` and `duse`, with no register.
  - A D-stage mfhi issued while `busy` stalls until the cycle after FIX, then reads the new value.
- Back-to-back MDU ops: the second stalls in D until `busy` = 0. It can start in the cycle immediately after E33, giving 34-cycle throughput.

## Structure
- Package `pipemdu_pkg`:
  - op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - state enum (IDLE, ITER, FIX);
  - `MDU_ITERS` = 32.
- One sub-module, `mdu_negate` (32/64-bit conditional two's-complement negate). It is instantiated for operand magnitude and for result fixup.
- Everything else sits in `pipemdu`: FSM, counter, datapath, HI/LO.

## Test plan
- mult: ea = 32'hFFFFFFFE (−2), eb = 3 → after 33 busy cycles, HI = 32'hFFFFFFFF, LO = 32'hFFFFFFFA. multu with the same operands → HI = 2, LO = 32'hFFFFFFFA.
- div: ea = −7, eb = 2 → LO = 32'hFFFFFFFD (−3), HI = 32'hFFFFFFFF (−1). divu: ea = 7, eb = 2 → LO = 3, HI = 1.
- div by zero: ea = 32'h12345678, eb = 0 → HI = 32'h12345678, LO = 32'hFFFFFFFF, 33 busy cycles.
- Stall: start mult, hold `duse` = 1 → `mdstall` high for exactly 33 cycles, low in the cycle after FIX. mthi(5) while idle → HI = 5 next cycle.
- Reset at ITER count 10 → next cycle busy = 0, HI = LO = 0. A new divu 100/7 then completes normally: LO = 14, HI = 2.
- Signed overflow: div 32'h80000000 / 32'hFFFFFFFF → LO = 32'h80000000, HI = 0.
